vga_pattern_gen: RTL and testbench
==================================

Name: vga_pattern_gen

Overview:
- Parametrised VGA test-pattern generator.
- Takes the live scan position from the VGA timing block and returns one registered pixel colour per clock.
- Supports five selectable patterns, including an animated bouncing box that updates once per frame.
- Sits between the VGA timing/sync generator and the colour DAC/output register stage.

Parameters:
- H_ACTIVE, 640, visible pixels per line; must be a multiple of 8.
- V_ACTIVE, 480, visible lines per frame.
- COLOR_W, 4, bits per colour channel; pixel is 3*COLOR_W bits.
- CHECK_LOG2, 5, checkerboard square size = 2^CHECK_LOG2 pixels.
- GRAD_SHIFT, 5, gradient level = x_pos >> GRAD_SHIFT.
- BOX_SIZE, 32, bouncing box edge length in pixels.
- BOX_STEP, 4, box movement per frame per axis in pixels.
- BOX_COLOR, {COLOR_W{1}} in red only, box colour.

Ports:
- vga_clk  in  1  pixel clock.
- vga_rst  in  1  asynchronous active-low reset.
- x_pos  in  10  horizontal scan position; counts through blanking.
- y_pos  in  10  vertical scan position; counts through blanking.
- mode_sel  in  3  requested pattern.
- solid_color  in  3*COLOR_W  colour for mode 0 and the mode 4 background.
- freeze  in  1  1 = hold box position.
- pixel_data  out  3*COLOR_W  registered colour, packed {blue, green, red}, blue in the MSBs.
- frame_count  out  8  frames completed; wraps 255 -> 0.

Behaviour:
- Reset (vga_rst=0, async): pixel_data=0, frame_count=0, active_mode=0, box_x=0, box_y=0, dir_x=+, dir_y=+, prev_pos=0.
- Frame event: one-cycle internal pulse when {x_pos,y_pos}==(0,V_ACTIVE) and prev_pos differs. prev_pos is the registered copy of {x_pos,y_pos}. A held position therefore gives exactly one pulse.
- On a frame event:
  - frame_count increments.
  - active_mode <= mode_sel.
  - Box updates unless freeze=1.
- mode_sel changes between events have no effect until the next event.
- Latency: pixel_data reflects x_pos/y_pos and active_mode sampled on the previous edge (1 cycle).
- Outside active area (x_pos>=H_ACTIVE or y_pos>=V_ACTIVE): pixel_data=0 in all modes.
- Mode 0 (solid): pixel = solid_color.
- Mode 1 (colour bars): bar = x_pos/(H_ACTIVE/8); bars 0..7 are white, yellow, cyan, green, magenta, red, blue, black. Each channel is fully on or 0.
- Mode 2 (checker): white when x_pos[CHECK_LOG2]^y_pos[CHECK_LOG2]=1, else black.
- Mode 3 (gray ramp): level = x_pos>>GRAD_SHIFT, saturated to 2^COLOR_W-1. All three channels equal level.
- Mode 4 (bouncing box): BOX_COLOR when box_x<=x_pos<box_x+BOX_SIZE and box_y<=y_pos<box_y+BOX_SIZE, else solid_color. Compare against the box registers as they stand; the update happens in blanking.
- Modes 5-7: black.
- Box update, X axis:
  - dir +: nx=box_x+BOX_STEP. If nx>H_ACTIVE-BOX_SIZE, then box_x=H_ACTIVE-BOX_SIZE and dir becomes -. Else box_x=nx.
  - dir -: if box_x<BOX_STEP, then box_x=0 and dir becomes +. Else box_x=box_x-BOX_STEP.
- Box update, Y axis: same rules with V_ACTIVE.
- Box position widths: 10 bits; comparisons must not overflow at the right/bottom edge. Use 11-bit intermediates.
- freeze=1 at an event: box and direction hold; frame_count and active_mode still update.
- Reset mid-frame: all state returns to reset values immediately. The first frame event after release is detected normally.

Test Plan:
- Reset then release, mode_sel=1, scan line y=10 -> pixel_data one cycle after x=0 is 12'hFFF; after x=80 is 12'h0FF; after x=400 is 12'h00F; after x=639 is 12'h000; after x=700 is 12'h000.
- mode_sel=2 latched, (x,y)=(32,0) -> 12'hFFF; (32,32) -> 12'h000; (0,0) -> 12'h000.
- mode_sel=3, x=0 -> 12'h000; x=64 -> 12'h222; x=600 -> 12'hFFF (saturated).
- mode_sel=0 driven mid-frame while active_mode=1 -> bars continue until the frame event, then solid_color; frame_count increments by exactly 1 even with the position held at (0,480) for 5 cycles.
- mode 4, freeze=0, 152 events -> box_x=608; event 153 -> box_x=608, dir -; event 154 -> 604. box_y reaches 448 at event 112 and stays 448 at event 113. Pixel (608,448) = BOX_COLOR.
- freeze=1 for 3 events -> box unchanged, frame_count +3. Assert vga_rst=0 mid-line -> pixel_data=0 and box at (0,0) without a clock edge.

Source files
------------

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | vga_pattern_gen : five-mode VGA test pattern generator, 1-cycle latency |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module vga_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int COLOR_W    = 4,
  parameter int CHECK_LOG2 = 5,
  parameter int GRAD_SHIFT = 5,
  parameter int BOX_SIZE   = 32,
  parameter int BOX_STEP   = 4,
  parameter logic [3*COLOR_W-1:0] BOX_COLOR = {{(2*COLOR_W){1'b0}}, {COLOR_W{1'b1}}}
) (
  input  logic                   vga_clk,
  input  logic                   vga_rst,
  input  logic [9:0]             x_pos,
  input  logic [9:0]             y_pos,
  input  logic [2:0]             mode_sel,
  input  logic [3*COLOR_W-1:0]   solid_color,
  input  logic                   freeze,
  output logic [3*COLOR_W-1:0]   pixel_data,
  output logic [7:0]             frame_count
);

  localparam int PIX_W = 3*COLOR_W;
  localparam logic [9:0]  BAR_W     = 10'(H_ACTIVE/8);
  localparam logic [10:0] H_LIM     = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM     = 11'(V_ACTIVE);
  localparam logic [10:0] X_MAX     = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] Y_MAX     = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] SIZE_11   = 11'(BOX_SIZE);
  localparam logic [10:0] STEP_11   = 11'(BOX_STEP);
  localparam logic [9:0]  LEVEL_MAX = 10'((1 << COLOR_W) - 1);
  localparam logic [COLOR_W-1:0] FULL = {COLOR_W{1'b1}};

  logic [PIX_W-1:0] pixel_q, pixel_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [9:0]       box_x_q, box_x_d, box_y_q, box_y_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [19:0]      prev_pos_q, prev_pos_d;

  logic             frame_evt, in_active, in_box;
  logic [2:0]       bar;
  logic [9:0]       level_full;
  logic [COLOR_W-1:0] level;
  logic [10:0]      x_11, y_11, bx_11, by_11, nx, ny;

  always_comb begin
    x_11  = {1'b0, x_pos};
    y_11  = {1'b0, y_pos};
    bx_11 = {1'b0, box_x_q};
    by_11 = {1'b0, box_y_q};

    // A held position at the event point must fire only once.
    frame_evt = (x_pos == 10'd0) && (y_11 == V_LIM) && (prev_pos_q != {x_pos, y_pos});
    prev_pos_d = {x_pos, y_pos};

    in_active = (x_11 < H_LIM) && (y_11 < V_LIM);
    in_box    = (x_11 >= bx_11) && (x_11 < bx_11 + SIZE_11) &&
                (y_11 >= by_11) && (y_11 < by_11 + SIZE_11);

    bar        = 3'(x_pos / BAR_W);
    level_full = x_pos >> GRAD_SHIFT;
    level      = (level_full > LEVEL_MAX) ? FULL : level_full[COLOR_W-1:0];

    pixel_d = '0;
    if (in_active) begin
      case (mode_q)
        3'd0: pixel_d = solid_color;
        // Bar order white..black maps to r=~bar[1], g=~bar[2], b=~bar[0].
        3'd1: pixel_d = {{COLOR_W{~bar[0]}}, {COLOR_W{~bar[2]}}, {COLOR_W{~bar[1]}}};
        3'd2: pixel_d = (x_pos[CHECK_LOG2] ^ y_pos[CHECK_LOG2]) ? {PIX_W{1'b1}} : '0;
        3'd3: pixel_d = {level, level, level};
        3'd4: pixel_d = in_box ? BOX_COLOR : solid_color;
        default: pixel_d = '0;
      endcase
    end

    frame_cnt_d = frame_cnt_q;
    mode_d      = mode_q;
    box_x_d     = box_x_q;
    box_y_d     = box_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    nx          = bx_11 + STEP_11;
    ny          = by_11 + STEP_11;

    if (frame_evt) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      mode_d      = mode_sel;
      if (!freeze) begin
        if (dir_x_q) begin
          if (nx > X_MAX) begin
            box_x_d = X_MAX[9:0];
            dir_x_d = 1'b0;
          end else begin
            box_x_d = nx[9:0];
          end
        end else if (bx_11 < STEP_11) begin
          box_x_d = '0;
          dir_x_d = 1'b1;
        end else begin
          box_x_d = box_x_q - STEP_11[9:0];
        end

        if (dir_y_q) begin
          if (ny > Y_MAX) begin
            box_y_d = Y_MAX[9:0];
            dir_y_d = 1'b0;
          end else begin
            box_y_d = ny[9:0];
          end
        end else if (by_11 < STEP_11) begin
          box_y_d = '0;
          dir_y_d = 1'b1;
        end else begin
          box_y_d = box_y_q - STEP_11[9:0];
        end
      end
    end
  end

  always_ff @(posedge vga_clk or negedge vga_rst) begin
    if (!vga_rst) begin
      pixel_q     <= '0;
      frame_cnt_q <= '0;
      mode_q      <= '0;
      box_x_q     <= '0;
      box_y_q     <= '0;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      prev_pos_q  <= '0;
    end else begin
      pixel_q     <= pixel_d;
      frame_cnt_q <= frame_cnt_d;
      mode_q      <= mode_d;
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      prev_pos_q  <= prev_pos_d;
    end
  end

  assign pixel_data  = pixel_q;
  assign frame_count = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_vga_pattern_gen : scoreboard bench for vga_pattern_gen               |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module tb_vga_pattern_gen;

  logic        vga_clk = 1'b0;
  logic        vga_rst;
  logic [9:0]  x_pos, y_pos;
  logic [2:0]  mode_sel;
  logic [11:0] solid_color;
  logic        freeze;
  logic [11:0] pixel_data;
  logic [7:0]  frame_count;

  always #5 vga_clk = ~vga_clk;

  vga_pattern_gen dut (
    .vga_clk     (vga_clk),
    .vga_rst     (vga_rst),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .mode_sel    (mode_sel),
    .solid_color (solid_color),
    .freeze      (freeze),
    .pixel_data  (pixel_data),
    .frame_count (frame_count)
  );

  localparam logic [11:0] SOLID = 12'h5A3;
  localparam logic [11:0] BOX   = 12'h00F;

  typedef struct {
    bit          is_fc;
    logic [11:0] exp;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  fc_model = 8'd0;

  function automatic void check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: registered outputs are compared half a cycle after the sampling edge.
  always @(negedge vga_clk) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      if (mon_e.is_fc) check(mon_e.name, {4'h0, frame_count}, mon_e.exp);
      else             check(mon_e.name, pixel_data, mon_e.exp);
    end
  end

  task automatic move(input logic [9:0] x, input logic [9:0] y);
    @(negedge vga_clk);
    x_pos = x;
    y_pos = y;
    @(posedge vga_clk);
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [11:0] exp, input string name);
    move(x, y);
    #1;
    sb_q.push_back('{is_fc: 1'b0, exp: exp, name: name});
  endtask

  task automatic frame_evt();
    move(10'd0, 10'd480);
    #1;
    fc_model = fc_model + 8'd1;
    sb_q.push_back('{is_fc: 1'b1, exp: {4'h0, fc_model}, name: "frame_count"});
    move(10'd1, 10'd480);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vga_rst     = 1'b0;
    x_pos       = 10'd0;
    y_pos       = 10'd0;
    mode_sel    = 3'd1;
    solid_color = SOLID;
    freeze      = 1'b1;
    repeat (3) @(posedge vga_clk);
    #1;
    sb_q.push_back('{is_fc: 1'b0, exp: 12'h000, name: "reset pixel"});
    sb_q.push_back('{is_fc: 1'b1, exp: 12'h000, name: "reset frame_count"});
    @(negedge vga_clk);
    vga_rst = 1'b1;

    pix(10'd5, 10'd10, SOLID, "mode0 after reset");
    frame_evt();
    pix(10'd0,   10'd10, 12'hFFF, "bar white");
    pix(10'd80,  10'd10, 12'h0FF, "bar yellow");
    pix(10'd400, 10'd10, 12'h00F, "bar red");
    pix(10'd639, 10'd10, 12'h000, "bar black");
    pix(10'd700, 10'd10, 12'h000, "bar blanking");

    mode_sel = 3'd2;
    pix(10'd100, 10'd10, 12'h0FF, "bars before event");
    frame_evt();
    pix(10'd32, 10'd0,  12'hFFF, "checker 32,0");
    pix(10'd32, 10'd32, 12'h000, "checker 32,32");
    pix(10'd0,  10'd0,  12'h000, "checker 0,0");
    pix(10'd0,  10'd32, 12'hFFF, "checker 0,32");

    mode_sel = 3'd3;
    frame_evt();
    pix(10'd0,   10'd5,   12'h000, "gray x0");
    pix(10'd64,  10'd5,   12'h222, "gray x64");
    pix(10'd600, 10'd5,   12'hFFF, "gray saturated");
    pix(10'd640, 10'd5,   12'h000, "gray right blank");
    pix(10'd10,  10'd480, 12'h000, "gray bottom blank");

    mode_sel = 3'd1;
    frame_evt();
    mode_sel = 3'd0;
    pix(10'd400, 10'd10, 12'h00F, "mode change deferred");
    for (int i = 0; i < 5; i++) move(10'd0, 10'd480);
    #1;
    fc_model = fc_model + 8'd1;
    sb_q.push_back('{is_fc: 1'b1, exp: {4'h0, fc_model}, name: "held event count"});
    move(10'd1, 10'd480);
    pix(10'd400, 10'd10, SOLID, "solid after event");

    mode_sel = 3'd4;
    frame_evt();
    pix(10'd0,  10'd0,  BOX,   "box origin");
    pix(10'd31, 10'd31, BOX,   "box far corner");
    pix(10'd32, 10'd0,  SOLID, "box right of edge");
    pix(10'd0,  10'd32, SOLID, "box below edge");

    freeze = 1'b0;
    repeat (112) frame_evt();
    pix(10'd448, 10'd448, BOX,   "box 448,448");
    pix(10'd447, 10'd448, SOLID, "box left of 448");
    pix(10'd448, 10'd447, SOLID, "box above 448");
    pix(10'd479, 10'd479, BOX,   "box bottom corner");
    frame_evt();
    pix(10'd452, 10'd448, BOX,   "box y held at 448");
    pix(10'd451, 10'd448, SOLID, "box x moved to 452");
    pix(10'd452, 10'd447, SOLID, "box y not past 448");
    repeat (39) frame_evt();
    pix(10'd608, 10'd292, BOX,   "box x 608");
    pix(10'd607, 10'd292, SOLID, "box left of 608");
    pix(10'd639, 10'd292, BOX,   "box right edge");
    pix(10'd640, 10'd292, 12'h000, "box blank past edge");
    frame_evt();
    pix(10'd608, 10'd288, BOX,   "box x held 608");
    pix(10'd607, 10'd288, SOLID, "box left of held 608");
    frame_evt();
    pix(10'd604, 10'd284, BOX,   "box x 604");
    pix(10'd603, 10'd284, SOLID, "box left of 604");
    pix(10'd635, 10'd284, BOX,   "box 604 last col");
    pix(10'd636, 10'd284, SOLID, "box 604 past col");

    freeze = 1'b1;
    repeat (3) frame_evt();
    pix(10'd604, 10'd284, BOX,   "frozen box");
    pix(10'd603, 10'd284, SOLID, "frozen box edge");

    pix(10'd610, 10'd290, BOX, "box before reset");
    @(posedge vga_clk);
    #2;
    vga_rst = 1'b0;
    #1;
    check("async reset pixel", pixel_data, 12'h000);
    check("async reset frame_count", {4'h0, frame_count}, 12'h000);
    fc_model = 8'd0;
    @(negedge vga_clk);
    vga_rst = 1'b1;
    frame_evt();
    pix(10'd0,  10'd0, BOX,   "box reset origin");
    pix(10'd32, 10'd0, SOLID, "box reset edge");

    repeat (2) @(negedge vga_clk);
    #1;
    check("scoreboard drained", 12'(sb_q.size()), 12'h000);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
